// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// stream, writes the payload into memory starting at LOAD_BASE, and releases
// the cpu reset only once the whole image has arrived with a good checksum.
//
// Handshake: a byte is taken on a rising CLK edge where BYTE_VALID and
// BYTE_READY are both 1; BYTE_IN is ignored on every other edge.
module prog_loader #(
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter logic [15:0] MAX_LEN   = 16'h0400
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DATA,
    output logic        MEM_WE,
    output logic        CPU_R,
    output logic        DONE,
    output logic        ERR,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] st_len_lo  = 3'd0;
    localparam logic [2:0] st_len_hi  = 3'd1;
    localparam logic [2:0] st_payload = 3'd2;
    localparam logic [2:0] st_write   = 3'd3;
    localparam logic [2:0] st_check   = 3'd4;
    localparam logic [2:0] st_done    = 3'd5;
    localparam logic [2:0] st_error   = 3'd6;

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] index;
    logic [7:0]  csum;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        ready_st;
    logic        accept;
    logic [15:0] len_full;
    logic [15:0] index_nxt;

    // Decode which states take a byte; R gates it so ready stays low in reset
    // and rises as soon as reset is released.
    always_comb begin
        ready_st = 1'b0;
        case (state)
            st_len_lo, st_len_hi, st_payload, st_check: ready_st = 1'b1;
            default:                                    ready_st = 1'b0;
        endcase
    end

    assign BYTE_READY = ready_st & ~R;
    assign accept     = BYTE_VALID & BYTE_READY;
    assign len_full   = {BYTE_IN, len_lo};
    assign index_nxt  = index + 16'd1;

    // Address/data are registers loaded on entry to st_write, so they hold
    // their last values in every other state.
    assign MEM_ADDR   = addr_q;
    assign MEM_DATA   = data_q;
    assign MEM_WE     = (state == st_write);
    assign CPU_R      = (state != st_done);
    assign DONE       = (state == st_done);
    assign ERR        = (state == st_error);
    assign state_dbg  = state;

    // Loader state machine with length, index, checksum and write registers.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state  <= st_len_lo;
            len_lo <= 8'h00;
            len    <= 16'h0000;
            index  <= 16'h0000;
            csum   <= 8'h00;
            addr_q <= 16'h0000;
            data_q <= 8'h00;
        end else begin
            case (state)
                st_len_lo: begin
                    if (accept) begin
                        len_lo <= BYTE_IN;
                        state  <= st_len_hi;
                    end
                end
                st_len_hi: begin
                    if (accept) begin
                        len <= len_full;
                        if (len_full > MAX_LEN) begin
                            state <= st_error;
                        end else if (len_full == 16'h0000) begin
                            state <= st_check;
                        end else begin
                            state <= st_payload;
                        end
                    end
                end
                st_payload: begin
                    if (accept) begin
                        data_q <= BYTE_IN;
                        addr_q <= LOAD_BASE + index;
                        csum   <= csum ^ BYTE_IN;
                        state  <= st_write;
                    end
                end
                st_write: begin
                    index <= index_nxt;
                    if (index_nxt == len) begin
                        state <= st_check;
                    end else begin
                        state <= st_payload;
                    end
                end
                st_check: begin
                    if (accept) begin
                        if (BYTE_IN == csum) begin
                            state <= st_done;
                        end else begin
                            state <= st_error;
                        end
                    end
                end
                st_done:  state <= st_done;
                st_error: state <= st_error;
                default:  state <= st_error;
            endcase
        end
    end

endmodule
